// File: rtl/wb_master.sv
// wb_master: Wishbone classic single-transfer initiator for the 8-bit MIDI router bus.
//
// Takes one read/write command at a time on a valid/ready port, runs a single Wishbone
// cycle and returns a one-cycle response strobe carrying read data (0 for writes).
//
// Ports:
//   wb_clk_i, wb_rst_i        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_we_i, cmd_addr_i,     command: 1 = write, target address, write data
//   cmd_data_i
//   rsp_valid_o, rsp_data_o,  one-cycle completion strobe, read data, timeout abort flag
//   rsp_err_o
//   wb_cyc_o, wb_stb_o,       Wishbone initiator side (cyc and stb always equal)
//   wb_we_o, wb_addr_o,
//   wb_dat_o, wb_dat_i,
//   wb_ack_i
//
// Build option: define WB_MASTER_TIMEOUT_EN to abort a bus cycle after TIMEOUT cycles
// without ack (rsp_err_o = 1). Without it, the bus waits forever and rsp_err_o is 0.

module wb_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

   logic       rsp_err_q, rsp_err_d;
   logic [7:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      addr_d      = addr_q;
      dat_d       = dat_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               we_d    = cmd_we_i;
               addr_d  = cmd_addr_i;
               dat_d   = cmd_data_i;
               cyc_d   = 1'b1;
               state_d = StBus;
`ifdef WB_MASTER_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         StBus: begin
            if (wb_ack_i) begin
               rsp_data_d  = we_q ? '0 : wb_dat_i;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
`ifdef WB_MASTER_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            // Abort at the edge where the counter would reach TIMEOUT, so stb stays up
            // for exactly TIMEOUT cycles; an ack in that last cycle still wins above.
            end else if (cnt_q + 8'd1 == TimeoutVal) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end else begin
               cnt_d       = cnt_q + 8'd1;
`endif
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q     <= StIdle;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
         cnt_q       <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
`ifdef WB_MASTER_TIMEOUT_EN
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   // Gated by reset so no command is taken while the block is held in reset.
   assign cmd_ready_o = (state_q == StIdle) && wb_rst_i;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_we_o     = we_q;
   assign wb_addr_o   = addr_q;
   assign wb_dat_o    = dat_q;

`ifdef WB_MASTER_TIMEOUT_EN
   assign rsp_err_o = rsp_err_q;
`else
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed bench for wb_master with a byte-RAM responder whose ack can be
// delayed by a programmable number of wait states, withheld, or forced outside a cycle.

module tb_wb_master;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic       cmd_we_i;
   logic [7:0] cmd_addr_i;
   logic [7:0] cmd_data_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic       rsp_err_o;
   logic       wb_cyc_o;
   logic       wb_stb_o;
   logic       wb_we_o;
   logic [7:0] wb_addr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i;
   logic       wb_ack_i;

   wb_master #(
      .ADDR_W (8),
      .DATA_W (8),
      .TIMEOUT(15)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i   (cmd_we_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_data_i (cmd_data_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o (rsp_data_o),
      .rsp_err_o  (rsp_err_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_addr_o  (wb_addr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Responder: byte RAM, ack after wait_n stalled strobe cycles
   logic [7:0] ram [256];
   int         wait_cnt = 0;
   int         wait_n   = 0;
   logic       ack_en    = 1'b1;
   logic       force_ack = 1'b0;

   assign wb_ack_i = force_ack | (wb_stb_o & ack_en & (wait_cnt >= wait_n));
   assign wb_dat_i = ram[wb_addr_o];

   always @(posedge wb_clk_i) begin
      if (!wb_stb_o) wait_cnt <= 0;
      else if (!wb_ack_i) wait_cnt <= wait_cnt + 1;
      if (wb_stb_o && wb_ack_i && wb_we_o) ram[wb_addr_o] <= wb_dat_o;
   end

   // Monitor: counts strobe cycles, response strobes and accepts seen at clock edges
   int cyc_num  = 0;
   int stb_cnt  = 0;
   int rsp_cnt  = 0;
   int acc_cnt  = 0;
   int acc_time = 0;
   int acc_prev = 0;

   always @(posedge wb_clk_i) begin
      if (wb_stb_o) stb_cnt++;
      if (rsp_valid_o) rsp_cnt++;
      if (cmd_valid_i && cmd_ready_o) begin
         acc_cnt++;
         acc_prev = acc_time;
         acc_time = cyc_num;
      end
      cyc_num++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] data);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
   endtask

   int stb0;
   int rsp0;
   int acc0;

   initial begin
      wb_rst_i    = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = 8'h00;
      cmd_data_i  = 8'h00;
      #2 wb_rst_i = 1'b0;
      #1;
      // Reset state
      check("rst_ready", 32'(cmd_ready_o), 32'h0);
      check("rst_stb", 32'(wb_stb_o), 32'h0);
      check("rst_cyc", 32'(wb_cyc_o), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      step();
      step();
      wb_rst_i = 1'b1;
      step();
      check("idle_ready", 32'(cmd_ready_o), 32'h1);
      check("idle_we", 32'(wb_we_o), 32'h0);
      check("idle_addr", 32'(wb_addr_o), 32'h0);
      check("idle_dat", 32'(wb_dat_o), 32'h0);
      check("idle_rsp_data", 32'(rsp_data_o), 32'h0);
      check("idle_rsp_err", 32'(rsp_err_o), 32'h0);

      // Zero-wait write 0xA5 -> 0x3C
      stb0 = stb_cnt;
      rsp0 = rsp_cnt;
      wait_n = 0;
      issue(1'b1, 8'h3C, 8'hA5);
      step();
      cmd_valid_i = 1'b0;
      check("wr_stb", 32'(wb_stb_o), 32'h1);
      check("wr_cyc", 32'(wb_cyc_o), 32'h1);
      check("wr_we", 32'(wb_we_o), 32'h1);
      check("wr_addr", 32'(wb_addr_o), 32'h3C);
      check("wr_dat", 32'(wb_dat_o), 32'hA5);
      check("wr_ready_bus", 32'(cmd_ready_o), 32'h0);
      step();
      check("wr_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("wr_rsp_data", 32'(rsp_data_o), 32'h0);
      check("wr_rsp_err", 32'(rsp_err_o), 32'h0);
      check("wr_stb_resp", 32'(wb_stb_o), 32'h0);
      check("wr_ready_resp", 32'(cmd_ready_o), 32'h0);
      step();
      check("wr_rsp_drop", 32'(rsp_valid_o), 32'h0);
      check("wr_ready_back", 32'(cmd_ready_o), 32'h1);
      check("wr_stb_cycles", 32'(stb_cnt - stb0), 32'd1);
      check("wr_rsp_pulses", 32'(rsp_cnt - rsp0), 32'd1);

      // Two back-to-back reads of 0x3C with cmd_valid held high
      acc0 = acc_cnt;
      issue(1'b0, 8'h3C, 8'hFF);
      step();
      check("rd_stb", 32'(wb_stb_o), 32'h1);
      check("rd_we", 32'(wb_we_o), 32'h0);
      step();
      check("rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("rd_rsp_data", 32'(rsp_data_o), 32'hA5);
      step();
      check("rd_ready_again", 32'(cmd_ready_o), 32'h1);
      check("rd_rsp_drop", 32'(rsp_valid_o), 32'h0);
      step();
      cmd_valid_i = 1'b0;
      check("rd_accepts", 32'(acc_cnt - acc0), 32'd2);
      check("rd_accept_gap", 32'(acc_time - acc_prev), 32'd3);
      step();
      check("rd2_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("rd2_rsp_data", 32'(rsp_data_o), 32'hA5);
      step();

      // Write with 4 wait states: strobe held 5 cycles, address/data stable
      stb0 = stb_cnt;
      wait_n = 4;
      issue(1'b1, 8'h55, 8'h3E);
      step();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("ws_stb", 32'(wb_stb_o), 32'h1);
         check("ws_addr", 32'(wb_addr_o), 32'h55);
         check("ws_dat", 32'(wb_dat_o), 32'h3E);
         check("ws_no_rsp", 32'(rsp_valid_o), 32'h0);
         step();
      end
      check("ws_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("ws_stb_low", 32'(wb_stb_o), 32'h0);
      check("ws_stb_cycles", 32'(stb_cnt - stb0), 32'd5);
      step();

      // Read 0x55 back with 2 wait states
      stb0 = stb_cnt;
      wait_n = 2;
      issue(1'b0, 8'h55, 8'h00);
      step();
      cmd_valid_i = 1'b0;
      step();
      step();
      check("ws_rd_no_rsp", 32'(rsp_valid_o), 32'h0);
      step();
      check("ws_rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("ws_rd_rsp_data", 32'(rsp_data_o), 32'h3E);
      check("ws_rd_stb_cycles", 32'(stb_cnt - stb0), 32'd3);
      step();

      // Ack outside BUS is ignored
      rsp0 = rsp_cnt;
      force_ack = 1'b1;
      step();
      step();
      force_ack = 1'b0;
      check("stray_ack_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("stray_ack_ready", 32'(cmd_ready_o), 32'h1);

      // Preload 0x10 = 0x77 for the timeout cases
      wait_n = 0;
      issue(1'b1, 8'h10, 8'h77);
      step();
      cmd_valid_i = 1'b0;
      step();
      step();

      // Ack on the 15th strobe cycle: completes normally either way
      stb0 = stb_cnt;
      wait_n = 14;
      issue(1'b0, 8'h10, 8'h00);
      step();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("ack15_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("ack15_rsp_err", 32'(rsp_err_o), 32'h0);
      check("ack15_rsp_data", 32'(rsp_data_o), 32'h77);
      check("ack15_stb_cycles", 32'(stb_cnt - stb0), 32'd15);
      step();

      // Ack withheld
      stb0 = stb_cnt;
      rsp0 = rsp_cnt;
      ack_en = 1'b0;
      wait_n = 0;
      issue(1'b0, 8'h10, 8'h00);
      step();
      cmd_valid_i = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         check("to_stb_held", 32'(wb_stb_o), 32'h1);
         step();
      end
      check("to_stb_low", 32'(wb_stb_o), 32'h0);
      check("to_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("to_rsp_err", 32'(rsp_err_o), 32'h1);
      check("to_rsp_data", 32'(rsp_data_o), 32'h0);
      check("to_stb_cycles", 32'(stb_cnt - stb0), 32'd15);
      ack_en = 1'b1;
      step();
`else
      for (int i = 0; i < 20; i++) step();
      check("noto_stb_held", 32'(wb_stb_o), 32'h1);
      check("noto_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("noto_err", 32'(rsp_err_o), 32'h0);
      ack_en = 1'b1;
      step();
      check("noto_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("noto_rsp_data", 32'(rsp_data_o), 32'h77);
      check("noto_rsp_err", 32'(rsp_err_o), 32'h0);
      step();
`endif
      step();

      // Reset asserted during BUS drops the transfer asynchronously
      ack_en = 1'b0;
      issue(1'b1, 8'h20, 8'h11);
      step();
      cmd_valid_i = 1'b0;
      check("mr_stb_before", 32'(wb_stb_o), 32'h1);
      step();
      #2 wb_rst_i = 1'b0;
      #1;
      check("mr_stb_async", 32'(wb_stb_o), 32'h0);
      check("mr_cyc_async", 32'(wb_cyc_o), 32'h0);
      check("mr_rsp_async", 32'(rsp_valid_o), 32'h0);
      check("mr_addr_async", 32'(wb_addr_o), 32'h0);
      check("mr_ready_in_rst", 32'(cmd_ready_o), 32'h0);
      step();
      wb_rst_i = 1'b1;
      ack_en = 1'b1;
      stb0 = stb_cnt;
      rsp0 = rsp_cnt;
      step();
      step();
      step();
      check("mr_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      check("mr_no_stb", 32'(stb_cnt - stb0), 32'd0);
      check("mr_ready", 32'(cmd_ready_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
